// File: rtl/matmul_job_scheduler.sv
// -----------------------------------------------------------------------------
// matmul_job_scheduler
//
// Shares one 4x4 systolic matmul controller between two requesters. Jobs are
// granted round-robin. The owner's 32-word operand packet (16 A words followed
// by 16 B words, row-major) is written into the controller's A/B memories. The
// array is then run until a rising edge on ctl_done, and the 16 C words are
// drained to the result port tagged with the owner id. If the array never
// reports done, the job is aborted after TIMEOUT RUN cycles with a one-cycle
// err pulse.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/ready/data     two word-streaming requesters (req_data packed,
//                            requester 0 in the low DW bits)
//   out_valid/ready/data     result stream, out_id = owner, out_last on C[15]
//   err                      one-cycle pulse when a RUN phase times out
//   busy                     high whenever a job is in progress
//   ctl_en, ctl_done         controller run enable / done indication
//   ctl_w_en_A/B, ctl_waddr, ctl_wdata   registered A/B memory write port
//   ctl_raddr_C, ctl_rdata_C C memory read port (data one cycle after address)
// -----------------------------------------------------------------------------
module matmul_job_scheduler #(
    parameter int DW      = 16,
    parameter int AW      = 7,
    parameter int CAW     = 5,
    parameter int NWORDS  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*DW-1:0]   req_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_id,
    output logic              out_last,
    output logic              err,
    output logic              busy,
    output logic              ctl_en,
    input  logic              ctl_done,
    output logic              ctl_w_en_A,
    output logic              ctl_w_en_B,
    output logic [AW-1:0]     ctl_waddr,
    output logic [DW-1:0]     ctl_wdata,
    output logic [CAW-1:0]    ctl_raddr_C,
    input  logic [DW-1:0]     ctl_rdata_C
);

    localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    // Drain sub-phases: D_WAIT only for the first word (address just issued),
    // D_CAP captures read data, D_OUT presents the word until accepted.
    typedef enum logic [1:0] {
        D_WAIT = 2'd0,
        D_CAP  = 2'd1,
        D_OUT  = 2'd2
    } dphase_t;

    state_t          state_q, state_d;
    dphase_t         dphase_q, dphase_d;
    logic            owner_q, owner_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [3:0]      idx_q, idx_d;
    logic [3:0]      k_q, k_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            done_q;
    logic            w_en_a_q, w_en_a_d;
    logic            w_en_b_q, w_en_b_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CAW-1:0]  raddr_q, raddr_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_id_q, out_id_d;
    logic            out_last_q, out_last_d;
    logic            err_q, err_d;

    // Split the packed requester data bus into per-requester words.
    logic [DW-1:0] req_word [2];
    for (genvar gi = 0; gi < 2; gi++) begin : g_req_word
        assign req_word[gi] = req_data[gi*DW +: DW];
    end

    logic          owner_valid;
    logic [DW-1:0] owner_word;
    logic          done_rise;

    assign owner_valid = req_valid[owner_q];
    assign owner_word  = req_word[owner_q];
    // Only a fresh rising edge completes a job; a level left high by an
    // earlier job is already reflected in done_q and is ignored.
    assign done_rise   = ctl_done && !done_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dphase_q    <= D_WAIT;
            owner_q     <= 1'b0;
            rr_ptr_q    <= 1'b0;
            idx_q       <= '0;
            k_q         <= '0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            w_en_a_q    <= 1'b0;
            w_en_b_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dphase_q    <= dphase_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            tmo_q       <= tmo_d;
            done_q      <= ctl_done;
            w_en_a_q    <= w_en_a_d;
            w_en_b_q    <= w_en_b_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        dphase_d    = dphase_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        k_d         = k_q;
        tmo_d       = tmo_q;
        w_en_a_d    = 1'b0;
        w_en_b_d    = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    // rr_ptr has priority; otherwise the other (valid) requester.
                    owner_d = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
                    idx_d   = '0;
                    state_d = S_LOAD_A;
                end
            end

            S_LOAD_A: begin
                if (owner_valid) begin
                    w_en_a_d = 1'b1;
                    waddr_d  = AW'(idx_q);
                    wdata_d  = owner_word;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_LOAD_B;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            S_LOAD_B: begin
                if (owner_valid) begin
                    w_en_b_d = 1'b1;
                    waddr_d  = AW'(idx_q);
                    wdata_d  = owner_word;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        tmo_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            S_RUN: begin
                if (done_rise) begin
                    k_d      = '0;
                    raddr_d  = '0;
                    dphase_d = D_WAIT;
                    state_d  = S_DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    // tmo_q counts RUN cycles already spent, so this is RUN cycle TIMEOUT.
                    err_d    = 1'b1;
                    rr_ptr_d = ~owner_q;
                    state_d  = S_IDLE;
                end else if (tmo_q != 8'hFF) begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            S_DRAIN: begin
                case (dphase_q)
                    D_WAIT: begin
                        dphase_d = D_CAP;
                    end
                    D_CAP: begin
                        out_valid_d = 1'b1;
                        out_data_d  = ctl_rdata_C;
                        out_id_d    = owner_q;
                        out_last_d  = (k_q == LAST_IDX);
                        // Prefetch the next address while this word waits at the
                        // output, so an accepted word goes straight to capture.
                        if (k_q != LAST_IDX) begin
                            raddr_d = CAW'(k_q + 4'd1);
                        end
                        dphase_d = D_OUT;
                    end
                    D_OUT: begin
                        if (out_ready) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            if (k_q == LAST_IDX) begin
                                rr_ptr_d = ~owner_q;
                                dphase_d = D_WAIT;
                                state_d  = S_IDLE;
                            end else begin
                                k_d      = k_q + 4'd1;
                                dphase_d = D_CAP;
                            end
                        end
                    end
                    default: begin
                        dphase_d = D_WAIT;
                    end
                endcase
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 2'b00;
        ctl_en    = 1'b0;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_LOAD_A, S_LOAD_B: req_ready[owner_q] = 1'b1;
            S_RUN:              ctl_en = 1'b1;
            default: ;
        endcase
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_id      = out_id_q;
    assign out_last    = out_last_q;
    assign err         = err_q;
    assign ctl_w_en_A  = w_en_a_q;
    assign ctl_w_en_B  = w_en_b_q;
    assign ctl_waddr   = waddr_q;
    assign ctl_wdata   = wdata_q;
    assign ctl_raddr_C = raddr_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
`timescale 1ns/1ps
module tb_matmul_job_scheduler;
    localparam int DW  = 16;
    localparam int AW  = 7;
    localparam int CAW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req_valid, req_ready;
    logic [2*DW-1:0]  req_data;
    logic             out_valid, out_ready, out_id, out_last, err, busy;
    logic             ctl_en, ctl_done, ctl_w_en_A, ctl_w_en_B;
    logic [DW-1:0]    out_data, ctl_wdata, ctl_rdata_C;
    logic [AW-1:0]    ctl_waddr;
    logic [CAW-1:0]   ctl_raddr_C;

    matmul_job_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_last(out_last), .err(err), .busy(busy),
        .ctl_en(ctl_en), .ctl_done(ctl_done),
        .ctl_w_en_A(ctl_w_en_A), .ctl_w_en_B(ctl_w_en_B),
        .ctl_waddr(ctl_waddr), .ctl_wdata(ctl_wdata),
        .ctl_raddr_C(ctl_raddr_C), .ctl_rdata_C(ctl_rdata_C)
    );

    int checks = 0;
    int errors = 0;
    logic gaps_en = 1'b0, flush = 1'b0, done_stuck = 1'b0, err_expected = 1'b0;
    int ready_mode = 0;
    int fixed_lat  = 10;
    logic [DW-1:0] drv_q0[$], drv_q1[$];
    logic [DW-1:0] exp_q0[$], exp_q1[$];
    int done_ids[$];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic sync_neg();
        @(negedge clk);
        #2;
    endtask

    // ---------------- requester drivers ----------------
    logic [1:0]    drv_v  = 2'b00;
    logic [1:0]    drv_hs = 2'b00;
    logic [DW-1:0] drv_d [2];
    assign req_valid = drv_v;
    assign req_data  = {drv_d[1], drv_d[0]};

    initial begin
        drv_d[0] = '0;
        drv_d[1] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (drv_hs[i]) begin
                    if (i == 0) void'(drv_q0.pop_front());
                    else        void'(drv_q1.pop_front());
                end
                if (flush) begin
                    if (i == 0) drv_q0.delete(); else drv_q1.delete();
                    drv_v[i] = 1'b0;
                end else if ((i == 0 ? drv_q0.size() : drv_q1.size()) > 0) begin
                    drv_v[i] = gaps_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                    drv_d[i] = (i == 0) ? drv_q0[0] : drv_q1[0];
                end else begin
                    drv_v[i] = 1'b0;
                end
            end
            #1;
            drv_hs = drv_v & req_ready;
        end
    end

    // ---------------- controller / memory model ----------------
    logic [DW-1:0] a_mem [16];
    logic [DW-1:0] b_mem [16];
    logic [DW-1:0] c_mem [16];

    always @(posedge clk) begin
        if (ctl_w_en_A) a_mem[ctl_waddr[3:0]] <= ctl_wdata;
        if (ctl_w_en_B) b_mem[ctl_waddr[3:0]] <= ctl_wdata;
        ctl_rdata_C <= c_mem[ctl_raddr_C[3:0]];
    end

    initial begin
        int run_cnt;
        int cur_lat;
        logic [31:0] s;
        ctl_done = 1'b0;
        run_cnt  = 0;
        cur_lat  = 0;
        for (int k = 0; k < 16; k++) c_mem[k] = '0;
        forever begin
            @(negedge clk);
            if (done_stuck) begin
                ctl_done = 1'b1;
            end else if (!ctl_en) begin
                ctl_done = 1'b0;
                run_cnt  = 0;
            end else if (!ctl_done) begin
                if (run_cnt == 0) cur_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(3, 30));
                run_cnt++;
                if (run_cnt >= cur_lat) begin
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++) begin
                            s = '0;
                            for (int j = 0; j < 4; j++)
                                s += 32'(a_mem[r*4+j]) * 32'(b_mem[j*4+c]);
                            c_mem[r*4+c] = s[DW-1:0];
                        end
                    ctl_done = 1'b1;
                end
            end
        end
    end

    // ---------------- job submission with reference result ----------------
    task automatic submit(input int id, input bit push_exp, input bit ident);
        logic [DW-1:0] a [16];
        logic [DW-1:0] b [16];
        logic [31:0]   s;
        for (int k = 0; k < 16; k++) begin
            if (ident) begin
                a[k] = DW'(k + 1);
                b[k] = ((k / 4) == (k % 4)) ? 16'd1 : 16'd0;
            end else begin
                a[k] = DW'($urandom);
                b[k] = DW'($urandom);
            end
        end
        for (int k = 0; k < 32; k++) begin
            if (id == 0) drv_q0.push_back(k < 16 ? a[k] : b[k-16]);
            else         drv_q1.push_back(k < 16 ? a[k] : b[k-16]);
        end
        if (push_exp) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    s = '0;
                    for (int j = 0; j < 4; j++) s += 32'(a[r*4+j]) * 32'(b[j*4+c]);
                    if (id == 0) exp_q0.push_back(s[DW-1:0]);
                    else         exp_q1.push_back(s[DW-1:0]);
                end
        end
    endtask

    // ---------------- output monitor / scoreboard ----------------
    initial begin
        int cyc;
        int wcnt [2];
        logic prev_stall;
        logic [DW-1:0] prev_data, e;
        logic prev_id, prev_last, have;
        cyc = 0; wcnt[0] = 0; wcnt[1] = 0; prev_stall = 1'b0;
        prev_data = '0; prev_id = 1'b0; prev_last = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check(out_valid && out_data == prev_data && out_id == prev_id && out_last == prev_last,
                          "hold_stable", {out_valid, out_id, out_last, out_data},
                          {1'b1, prev_id, prev_last, prev_data});
                if (out_valid) check(busy, "valid_only_in_drain", busy, 1);
                if (err) check(err_expected, "unexpected_err", err, 0);
                if (out_valid && out_ready) begin
                    have = 1'b0;
                    e = '0;
                    if (!out_id && exp_q0.size() > 0)     begin e = exp_q0.pop_front(); have = 1'b1; end
                    else if (out_id && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                    check(have, "unexpected_word", out_id, 0);
                    if (have) begin
                        check(out_data == e, "word_data", out_data, e);
                        check(out_last == (wcnt[out_id] == 15), "word_last", out_last, (wcnt[out_id] == 15));
                        $display("out id=%0d k=%0d data=%h last=%0d", out_id, wcnt[out_id], out_data, out_last);
                        wcnt[out_id] = (wcnt[out_id] == 15) ? 0 : wcnt[out_id] + 1;
                        if (out_last) done_ids.push_back(int'(out_id));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_id    = out_id;
                prev_last  = out_last;
            end
        end
    end

    task automatic wait_idle(input int maxc, input string name);
        int  c;
        bit  ok;
        c = 0; ok = 1'b0;
        while (c < maxc && !ok) begin
            sync_neg();
            c++;
            ok = (drv_q0.size() == 0 && drv_q1.size() == 0 && exp_q0.size() == 0 &&
                  exp_q1.size() == 0 && !busy && drv_v == 2'b00);
        end
        check(ok, name, c, maxc);
    endtask

    function automatic logic [53:0] all_outs();
        return {req_ready, out_valid, out_data, out_id, out_last, err, busy, ctl_en,
                ctl_w_en_A, ctl_w_en_B, ctl_waddr, ctl_wdata, ctl_raddr_C};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int exp_order [4];
        int cnt;
        bit got;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

        // 1: reset with requester 0 already valid
        rst = 1'b1;
        submit(0, 1'b1, 1'b1);
        repeat (3) begin
            sync_neg();
            check(all_outs() == '0, "reset_outputs", all_outs(), 0);
        end
        rst = 1'b0;

        // 2: identity job from requester 0, done after 10 cycles
        wait_idle(2000, "identity_job_timeout");
        check(done_ids.size() == 1 && done_ids[0] == 0, "identity_owner", done_ids.size(), 1);

        // 3: both requesters from reset, twice
        rst = 1'b1;
        sync_neg(); sync_neg();
        rst = 1'b0;
        done_ids.delete();
        fixed_lat = 0;
        submit(0, 1'b1, 1'b0);
        submit(1, 1'b1, 1'b0);
        wait_idle(3000, "rr_round1_timeout");
        submit(0, 1'b1, 1'b0);
        submit(1, 1'b1, 1'b0);
        wait_idle(3000, "rr_round2_timeout");
        check(done_ids.size() == 4, "rr_job_count", done_ids.size(), 4);
        for (int i = 0; i < 4 && i < done_ids.size(); i++)
            check(done_ids[i] == exp_order[i], "rr_order", done_ids[i], exp_order[i]);

        // 4: random jobs, throttled sink, gappy requesters
        ready_mode = 1;
        gaps_en    = 1'b1;
        repeat (4) submit(int'($urandom_range(0, 1)), 1'b1, 1'b0);
        wait_idle(20000, "stall_jobs_timeout");
        ready_mode = 2;
        repeat (4) submit(int'($urandom_range(0, 1)), 1'b1, 1'b0);
        wait_idle(20000, "random_jobs_timeout");

        // 5: stale done held high -> timeout abort
        ready_mode   = 0;
        gaps_en      = 1'b0;
        done_stuck   = 1'b1;
        err_expected = 1'b1;
        submit(0, 1'b0, 1'b0);
        cnt = 0; got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            sync_neg();
            if (err) got = 1'b1;
            else if (ctl_en) cnt++;
        end
        check(got, "timeout_err_seen", got, 1);
        check(cnt == 255, "timeout_run_cycles", cnt, 255);
        check(!busy && !ctl_en, "timeout_idle", {busy, ctl_en}, 0);
        sync_neg();
        check(!err, "err_one_cycle", err, 0);
        err_expected = 1'b0;
        done_stuck   = 1'b0;
        sync_neg();

        // 6: reset in the middle of LOAD_B, then a fresh requester-1 job
        submit(0, 1'b1, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            sync_neg();
            if (ctl_w_en_B && ctl_waddr == 7'd7) got = 1'b1;
        end
        check(got, "loadb_idx7_seen", got, 1);
        rst   = 1'b1;
        flush = 1'b1;
        exp_q0.delete();
        sync_neg();
        check(all_outs() == '0, "mid_reset_outputs", all_outs(), 0);
        sync_neg();
        rst   = 1'b0;
        flush = 1'b0;
        done_ids.delete();
        submit(1, 1'b1, 1'b0);
        wait_idle(3000, "post_reset_job_timeout");
        check(done_ids.size() == 1 && done_ids[0] == 1, "post_reset_owner", done_ids.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
